// File: rtl/demux2x32_stage_pkg.sv
// Shared definitions for the buffered 1-to-2 word demultiplexer.
//   DATA_W   : datapath word width
//   PORT_WB  : Select value routing to the writeback consumer (port 0)
//   PORT_MEM : Select value routing to the store/memory consumer (port 1)
package demux2x32_stage_pkg;
  localparam int   DATA_W   = 32;
  localparam logic PORT_WB  = 1'b0;
  localparam logic PORT_MEM = 1'b1;

  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/demux2x32_stage_if.sv
// Producer/consumer bundle for demux2x32_stage.
//   DataIn/InValid/Select/InReady : producer stream
//   DataOutN/ValidN/ReadyN        : consumer stream N (0 = writeback, 1 = memory)
//   CountN                        : words delivered on port N since reset
// master: the environment side (producer + consumers); slave: the demux.
interface demux2x32_stage_if
  import demux2x32_stage_pkg::*;
#(
  parameter int CW = 16
) ();
  word_t         DataIn;
  logic          InValid;
  logic          Select;
  logic          InReady;
  word_t         DataOut0;
  word_t         DataOut1;
  logic          Valid0;
  logic          Valid1;
  logic          Ready0;
  logic          Ready1;
  logic [CW-1:0] Count0;
  logic [CW-1:0] Count1;

  modport master (
    output DataIn, InValid, Select, Ready0, Ready1,
    input  InReady, DataOut0, DataOut1, Valid0, Valid1, Count0, Count1
  );

  modport slave (
    input  DataIn, InValid, Select, Ready0, Ready1,
    output InReady, DataOut0, DataOut1, Valid0, Valid1, Count0, Count1
  );
endinterface

// File: rtl/demux2x32_stage_sync_fifo32.sv
// Synchronous FIFO of 32-bit words, DEPTH entries (power of two, 2..16).
//   clk, rst_n : clock, synchronous active-low reset
//   push_i     : write data_i (ignored when full)
//   data_i     : word to write
//   pop_i      : release head word (ignored when empty)
//   full_o     : DEPTH words held
//   empty_o    : no words held
//   data_o     : head word; when empty, the last word popped (0 after reset)
module sync_fifo32
  import demux2x32_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  word_t data_i,
  input  logic  pop_i,
  output logic  full_o,
  output logic  empty_o,
  output word_t data_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  word_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]  occ_q, occ_d;
  word_t          last_q, last_d;
  logic           do_push, do_pop;

  // Flags decode registered occupancy only, so they never depend on
  // same-cycle push/pop activity.
  assign full_o  = (occ_q == OW'(DEPTH));
  assign empty_o = (occ_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Last-popped word is shown while empty so the output never shows a
  // stale slot that was never delivered.
  assign data_o  = empty_o ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    last_d   = last_q;
    // Pointers are AW bits wide, so +1 wraps modulo DEPTH.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      last_q   <= last_d;
    end
  end

  // Storage carries no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/demux2x32_stage.sv
// Buffered 1-to-2 demultiplexer: steers the producer word stream into one of
// two independently buffered consumer streams, so a stall on one consumer
// does not block words bound for the other.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : producer/consumer bundle (slave side), see demux2x32_stage_if
// Parameters: DEPTH entries per port FIFO, CW bits per delivered-word counter.
module demux2x32_stage
  import demux2x32_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  demux2x32_stage_if.slave  bus
);
  logic          full0, empty0, full1, empty1;
  logic          accept, push0, push1, pop0, pop1;
  logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Ready is a function of Select and registered fullness only; a pop in
  // the same cycle does not open a slot until the next cycle.
  assign bus.InReady = (bus.Select == PORT_MEM) ? !full1 : !full0;
  assign accept      = bus.InValid && bus.InReady;
  assign push0       = accept && (bus.Select == PORT_WB);
  assign push1       = accept && (bus.Select == PORT_MEM);
  assign pop0        = !empty0 && bus.Ready0;
  assign pop1        = !empty1 && bus.Ready1;

  assign bus.Valid0  = !empty0;
  assign bus.Valid1  = !empty1;
  assign bus.Count0  = cnt0_q;
  assign bus.Count1  = cnt1_q;

  sync_fifo32 #(.DEPTH(DEPTH)) u_fifo_wb (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push0),
    .data_i  (bus.DataIn),
    .pop_i   (pop0),
    .full_o  (full0),
    .empty_o (empty0),
    .data_o  (bus.DataOut0)
  );

  sync_fifo32 #(.DEPTH(DEPTH)) u_fifo_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push1),
    .data_i  (bus.DataIn),
    .pop_i   (pop1),
    .full_o  (full1),
    .empty_o (empty1),
    .data_o  (bus.DataOut1)
  );

  // Delivered-word counters wrap silently modulo 2^CW.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (pop0) cnt0_d = cnt0_q + 1'b1;
    if (pop1) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
endmodule

// File: tb/tb_demux2x32_stage.sv
// Directed bench for demux2x32_stage (DEPTH = 2, CW = 16). Inputs change 1ns
// after the rising edge; outputs are sampled on the falling edge.
module tb_demux2x32_stage;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  demux2x32_stage_if #(.CW(16)) bus ();

  demux2x32_stage #(.DEPTH(2), .CW(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int rcv;
    int guard;

    // Reset with a word presented: it must not be stored.
    rst_n       = 1'b0;
    bus.InValid = 1'b1;
    bus.Select  = 1'b0;
    bus.DataIn  = 32'hDEADBEEF;
    bus.Ready0  = 1'b0;
    bus.Ready1  = 1'b0;
    cyc();
    cyc();
    rst_n       = 1'b1;
    bus.InValid = 1'b0;
    @(negedge clk);
    check("rst_valid0", 32'(bus.Valid0), 32'd0);
    check("rst_valid1", 32'(bus.Valid1), 32'd0);
    check("rst_count0", 32'(bus.Count0), 32'd0);
    check("rst_count1", 32'(bus.Count1), 32'd0);
    check("rst_dout0", bus.DataOut0, 32'd0);
    check("rst_dout1", bus.DataOut1, 32'd0);
    check("rst_inready_s0", 32'(bus.InReady), 32'd1);
    bus.Select = 1'b1;
    #1;
    check("rst_inready_s1", 32'(bus.InReady), 32'd1);
    cyc();
    @(negedge clk);
    check("rst_nostore0", 32'(bus.Valid0), 32'd0);
    check("rst_nostore1", 32'(bus.Valid1), 32'd0);

    // Routing: one word to each port, consumers always ready.
    cyc();
    bus.Ready0  = 1'b1;
    bus.Ready1  = 1'b1;
    bus.InValid = 1'b1;
    bus.Select  = 1'b0;
    bus.DataIn  = 32'hAAAA0001;
    @(negedge clk);
    check("route_inready0", 32'(bus.InReady), 32'd1);
    cyc();
    bus.Select = 1'b1;
    bus.DataIn = 32'hBBBB0002;
    @(negedge clk);
    check("route_valid0", 32'(bus.Valid0), 32'd1);
    check("route_dout0", bus.DataOut0, 32'hAAAA0001);
    check("route_valid1_idle", 32'(bus.Valid1), 32'd0);
    cyc();
    bus.InValid = 1'b0;
    @(negedge clk);
    check("route_valid0_done", 32'(bus.Valid0), 32'd0);
    check("route_valid1", 32'(bus.Valid1), 32'd1);
    check("route_dout1", bus.DataOut1, 32'hBBBB0002);
    check("route_count0", 32'(bus.Count0), 32'd1);
    cyc();
    @(negedge clk);
    check("route_valid1_done", 32'(bus.Valid1), 32'd0);
    check("route_count1", 32'(bus.Count1), 32'd1);
    check("route_dout0_hold", bus.DataOut0, 32'hAAAA0001);

    // Backpressure isolation: port 0 stalled and filled, port 1 still flows.
    cyc();
    bus.Ready0  = 1'b0;
    bus.InValid = 1'b1;
    bus.Select  = 1'b0;
    bus.DataIn  = 32'h00000001;
    cyc();
    bus.DataIn  = 32'h00000002;
    cyc();
    bus.DataIn  = 32'h00000003;
    @(negedge clk);
    check("bp_full_inready", 32'(bus.InReady), 32'd0);
    bus.Select = 1'b1;
    bus.DataIn = 32'h12345678;
    #1;
    check("bp_port1_inready", 32'(bus.InReady), 32'd1);
    cyc();
    bus.InValid = 1'b0;
    @(negedge clk);
    check("bp_valid1", 32'(bus.Valid1), 32'd1);
    check("bp_dout1", bus.DataOut1, 32'h12345678);
    check("bp_head0", bus.DataOut0, 32'h00000001);
    cyc();
    @(negedge clk);
    check("bp_count1", 32'(bus.Count1), 32'd2);
    check("bp_count0_stalled", 32'(bus.Count0), 32'd1);

    // Full with simultaneous pop: no same-cycle pass-through.
    cyc();
    bus.Ready0  = 1'b1;
    bus.InValid = 1'b1;
    bus.Select  = 1'b0;
    bus.DataIn  = 32'h00000003;
    @(negedge clk);
    check("fp_inready_full", 32'(bus.InReady), 32'd0);
    check("fp_order1", bus.DataOut0, 32'h00000001);
    cyc();
    @(negedge clk);
    check("fp_inready_next", 32'(bus.InReady), 32'd1);
    check("fp_order2", bus.DataOut0, 32'h00000002);
    cyc();
    bus.InValid = 1'b0;
    @(negedge clk);
    check("fp_valid3", 32'(bus.Valid0), 32'd1);
    check("fp_order3", bus.DataOut0, 32'h00000003);
    cyc();
    @(negedge clk);
    check("fp_empty", 32'(bus.Valid0), 32'd0);
    check("fp_count0", 32'(bus.Count0), 32'd4);

    // Wrap: 100 words to port 1 with a randomly stalling consumer.
    cyc();
    bus.Ready0 = 1'b0;
    sent  = 0;
    rcv   = 0;
    guard = 0;
    while (rcv < 100 && guard < 2000) begin
      bus.InValid = (sent < 100);
      bus.Select  = 1'b1;
      bus.DataIn  = 32'h50000000 + 32'(sent);
      bus.Ready1  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.Valid1 && bus.Ready1) begin
        check("wrap_data", bus.DataOut1, 32'h50000000 + 32'(rcv));
        rcv++;
      end
      if (bus.InValid && bus.InReady) sent++;
      cyc();
      guard++;
    end
    bus.InValid = 1'b0;
    bus.Ready1  = 1'b1;
    check("wrap_received", 32'(rcv), 32'd100);
    @(negedge clk);
    check("wrap_drained", 32'(bus.Valid1), 32'd0);
    check("wrap_count1", 32'(bus.Count1), 32'd102);
    check("wrap_port0_quiet", 32'(bus.Valid0), 32'd0);

    // Mid-stream reset discards buffered words on port 0.
    cyc();
    bus.Ready0  = 1'b0;
    bus.InValid = 1'b1;
    bus.Select  = 1'b0;
    bus.DataIn  = 32'h00000011;
    cyc();
    bus.DataIn  = 32'h00000022;
    cyc();
    bus.InValid = 1'b0;
    @(negedge clk);
    check("mr_held", 32'(bus.Valid0), 32'd1);
    check("mr_head", bus.DataOut0, 32'h00000011);
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n      = 1'b1;
    bus.Ready0 = 1'b1;
    @(negedge clk);
    check("mr_valid0", 32'(bus.Valid0), 32'd0);
    check("mr_count0", 32'(bus.Count0), 32'd0);
    check("mr_count1", 32'(bus.Count1), 32'd0);
    check("mr_dout0", bus.DataOut0, 32'd0);
    for (int i = 0; i < 3; i++) cyc();
    @(negedge clk);
    check("mr_no_emerge", 32'(bus.Valid0), 32'd0);
    check("mr_count0_still", 32'(bus.Count0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
